// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, default FIFO depth and a width helper.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned UART_TX_FIFO_DEPTH = 16;

  // Ceiling log2 for parameter elaboration; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte register array with one synchronous write port and one async read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];

  // Storage is intentionally not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter, with occupancy, almost-full and a
// sticky high-water mark. Define UART_TX_FIFO_FLUSH_EN to add the io_flush
// synchronous clear input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = UART_TX_FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = 12,
  localparam int unsigned AW = clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic          io_flush,
`endif
  input  logic          io_enq_valid,
  output logic          io_enq_ready,
  input  logic [7:0]    io_enq_bits,
  output logic          io_deq_valid,
  input  logic          io_deq_ready,
  output logic [7:0]    io_deq_bits,
  output logic [PW-1:0] io_count,
  output logic          io_almost_full,
  output logic [PW-1:0] io_max_level
);

  localparam logic [PW-1:0] AfLvl = PW'(AF_LEVEL);
  localparam logic [PW-1:0] One   = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] max_q, max_d;
  logic          empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef UART_TX_FIFO_FLUSH_EN
  assign io_enq_ready = ~full & ~io_flush;
  assign pop          = ~empty & io_deq_ready & ~io_flush;
`else
  assign io_enq_ready = ~full;
  assign pop          = ~empty & io_deq_ready;
`endif
  assign push         = io_enq_valid & io_enq_ready;

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (io_enq_bits),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (io_deq_bits)
  );

  // Next-state for pointers, occupancy and high-water mark.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + One : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + One : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
`ifdef UART_TX_FIFO_FLUSH_EN
    // Push is already suppressed during flush, so wr_ptr_q is final.
    if (io_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
`endif
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  // State registers; async active-low clear, array excluded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end

  assign io_deq_valid   = ~empty;
  assign io_count       = count_q;
  assign io_max_level   = max_q;
  assign io_almost_full = (count_q >= AfLvl);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, AF_LEVEL=12).
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       io_enq_valid;
  logic       io_enq_ready;
  logic [7:0] io_enq_bits;
  logic       io_deq_valid;
  logic       io_deq_ready;
  logic [7:0] io_deq_bits;
  logic [4:0] io_count;
  logic       io_almost_full;
  logic [4:0] io_max_level;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic       io_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (12)
  ) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef UART_TX_FIFO_FLUSH_EN
    .io_flush       (io_flush),
`endif
    .io_enq_valid   (io_enq_valid),
    .io_enq_ready   (io_enq_ready),
    .io_enq_bits    (io_enq_bits),
    .io_deq_valid   (io_deq_valid),
    .io_deq_ready   (io_deq_ready),
    .io_deq_bits    (io_deq_bits),
    .io_count       (io_count),
    .io_almost_full (io_almost_full),
    .io_max_level   (io_max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = base + 8'(i);
      tick();
    end
    io_enq_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] base, input int n);
    io_deq_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, 32'(io_deq_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(io_deq_bits), 32'(base + 8'(i)));
      tick();
    end
    io_deq_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [7:0] burst [20];
  int sent, rcvd;

  initial begin
    reset        = 1'b0;
    io_enq_valid = 1'b0;
    io_enq_bits  = 8'h00;
    io_deq_ready = 1'b0;
`ifdef UART_TX_FIFO_FLUSH_EN
    io_flush     = 1'b0;
`endif
    do_reset();

    // Reset values
    check_eq("rst_enq_ready", 32'(io_enq_ready), 32'd1);
    check_eq("rst_deq_valid", 32'(io_deq_valid), 32'd0);
    check_eq("rst_count", 32'(io_count), 32'd0);
    check_eq("rst_max", 32'(io_max_level), 32'd0);
    check_eq("rst_af", 32'(io_almost_full), 32'd0);

    // Reset asserted mid-burst at count=5 clears immediately
    push_seq(8'h10, 5);
    check_eq("burst_count5", 32'(io_count), 32'd5);
    io_enq_valid = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("midrst_count", 32'(io_count), 32'd0);
    check_eq("midrst_max", 32'(io_max_level), 32'd0);
    check_eq("midrst_deq_valid", 32'(io_deq_valid), 32'd0);
    check_eq("midrst_enq_ready", 32'(io_enq_ready), 32'd1);
    io_enq_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Fill: almost_full from the 12th push, not-ready after the 16th
    for (int i = 0; i < 16; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = 8'(i);
      tick();
      check_eq("fill_count", 32'(io_count), 32'(i + 1));
      check_eq("fill_af", 32'(io_almost_full), 32'((i + 1) >= 12));
      check_eq("fill_ready", 32'(io_enq_ready), 32'((i + 1) < 16));
    end
    io_enq_bits = 8'hAA;
    tick();
    io_enq_valid = 1'b0;
    check_eq("drop17_count", 32'(io_count), 32'd16);
    pop_check("drain", 8'h00, 16);
    check_eq("drain_empty", 32'(io_deq_valid), 32'd0);
    check_eq("drain_count", 32'(io_count), 32'd0);
    check_eq("drain_max", 32'(io_max_level), 32'd16);
    check_eq("drain_af", 32'(io_almost_full), 32'd0);

    // Wrap-around across the index boundary
    push_seq(8'h20, 10);
    pop_check("wrap_a", 8'h20, 10);
    check_eq("wrap_mid_count", 32'(io_count), 32'd0);
    push_seq(8'h30, 12);
    check_eq("wrap_count12", 32'(io_count), 32'd12);
    pop_check("wrap_b", 8'h30, 12);
    check_eq("wrap_end_count", 32'(io_count), 32'd0);
    check_eq("wrap_end_valid", 32'(io_deq_valid), 32'd0);

    // Simultaneous push/pop while full: pop wins, push ignored
    push_seq(8'h40, 16);
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h99;
    io_deq_ready = 1'b1;
    check_eq("full_head", 32'(io_deq_bits), 32'h40);
    tick();
    io_deq_ready = 1'b0;
    check_eq("full_pp_count", 32'(io_count), 32'd15);
    check_eq("full_pp_ready", 32'(io_enq_ready), 32'd1);
    tick();
    io_enq_valid = 1'b0;
    check_eq("full_push_count", 32'(io_count), 32'd16);
    pop_check("full_drain", 8'h41, 15);
    pop_check("full_tail", 8'h99, 1);
    check_eq("full_end_count", 32'(io_count), 32'd0);

    // Transmitter-paced drain: ready one cycle in ten, 20-byte burst
    for (int i = 0; i < 20; i++) burst[i] = 8'($urandom_range(0, 255));
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      io_enq_valid = (sent < 20);
      io_enq_bits  = (sent < 20) ? burst[sent] : 8'h00;
      io_deq_ready = ((cyc % 10) == 9);
      #1;
      if (io_deq_valid && io_deq_ready) begin
        check_eq("paced_data", 32'(io_deq_bits), 32'(burst[rcvd]));
        rcvd++;
      end
      if (io_enq_valid && io_enq_ready) sent++;
      tick();
    end
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    check_eq("paced_rcvd", 32'(rcvd), 32'd20);
    check_eq("paced_sent", 32'(sent), 32'd20);
    check_eq("paced_count", 32'(io_count), 32'd0);

`ifdef UART_TX_FIFO_FLUSH_EN
    // Flush at count=7 with a concurrent enqueue
    do_reset();
    push_seq(8'h60, 7);
    check_eq("fl_pre_count", 32'(io_count), 32'd7);
    io_flush     = 1'b1;
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'hEE;
    #1;
    check_eq("fl_enq_ready", 32'(io_enq_ready), 32'd0);
    tick();
    io_flush     = 1'b0;
    io_enq_valid = 1'b0;
    check_eq("fl_count", 32'(io_count), 32'd0);
    check_eq("fl_deq_valid", 32'(io_deq_valid), 32'd0);
    check_eq("fl_max", 32'(io_max_level), 32'd7);
    push_seq(8'h55, 1);
    check_eq("fl_after_count", 32'(io_count), 32'd1);
    pop_check("fl_after", 8'h55, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO placed directly upstream of the UART transmitter's enq interface.
- Absorbs bursts from a host or CPU-side producer and feeds bytes one at a time to the transmitter, which accepts only when idle (about 10 bit-times per byte).
- Uses the same decoupled valid/ready convention on both sides.
- Reports occupancy, an almost-full threshold and a sticky high-water mark.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- AF_LEVEL, 12, occupancy at or above which io_almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0). Async assert, sync deassert is handled upstream.
- io_enq_valid  in  1  producer byte valid.
- io_enq_ready  out  1  FIFO can accept; equals not-full.
- io_enq_bits  in  8  producer byte.
- io_deq_valid  out  1  head byte available; equals not-empty. Connects to transmitter enq_valid.
- io_deq_ready  in  1  transmitter enq_ready.
- io_deq_bits  out  8  head byte; connects to transmitter enq_bits.
- io_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- io_almost_full  out  1  io_count >= AF_LEVEL.
- io_max_level  out  clog2(DEPTH)+1  sticky maximum io_count seen since reset.

Behaviour:
- Storage: DEPTH x 8 register array.
- Pointers: wr_ptr and rd_ptr, each clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Pointers increment modulo 2*DEPTH; the natural overflow of the extra bit gives the wrap.
- Push = io_enq_valid & io_enq_ready. Writes mem[wr_ptr index] and increments wr_ptr.
- Pop = io_deq_valid & io_deq_ready. Increments rd_ptr.
- io_deq_bits = mem[rd_ptr index], combinational read (show-ahead). The value is stable while io_deq_valid=1 and no pop occurs.
- Latency: a byte pushed in cycle N gives io_deq_valid=1 in cycle N+1. There is no same-cycle bypass when empty.
- Full: io_enq_ready=0, push is ignored, and a simultaneous pop still occurs. There is no write-through when full.
- Empty: io_deq_valid=0, io_deq_ready is ignored, io_deq_bits is don't-care (the stale entry).
- Simultaneous push and pop, neither full nor empty: both pointers advance and the count is unchanged.
- io_count is a register, updated +1 on push only, -1 on pop only, unchanged otherwise. It must equal wr_ptr - rd_ptr at all times.
- io_max_level is a register. The next value is the larger of io_max_level and next io_count; it never decreases until reset.
- io_almost_full is combinational from io_count.
- Reset (reset=0, any time including mid-burst):
  - pointers, count and max_level go to 0 immediately.
  - Outputs: io_enq_ready=1, io_deq_valid=0, io_count=0, io_almost_full=0, io_max_level=0.
  - Array contents are not reset.
- The producer must hold valid/bits until ready; the FIFO does not check this.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- Defined: adds input port io_flush (1 bit), a synchronous clear.
  - When io_flush=1 on a clock edge: rd_ptr <= wr_ptr-after-push-suppression and io_count <= 0.
  - Push and pop in that cycle are discarded, and io_enq_ready is forced to 0 during the flush cycle.
  - io_max_level is unaffected.
- Undefined: no io_flush port and no flush logic.

Decomposition:
- Shared package uart_pkg:
  - byte_t (8-bit) typedef.
  - UART_TX_FIFO_DEPTH default constant.
  - ptr-width helper function clog2.
- Optional sub-module uart_fifo_mem: register array with one write port and one async read port, parameterised by DEPTH.
- Pointer, count and flag logic stays in uart_tx_fifo.

Test Plan:
- Reset release:
  - Expect io_enq_ready=1, io_deq_valid=0, io_count=0, io_max_level=0.
  - Assert reset mid-burst at count=5 -> all return to 0 within the same cycle.
- Fill and drain with DEPTH=16, AF_LEVEL=12, io_deq_ready=0:
  - Push 0x00..0x0F -> io_almost_full rises after the 12th push, io_enq_ready=0 after the 16th.
  - A 17th push of 0xAA is dropped.
  - io_deq_ready=1 -> pops 0x00..0x0F in order, then io_deq_valid=0, io_max_level=16.
- Wrap-around:
  - Push 10, pop 10, push 12 bytes 0x30..0x3B, pop all -> order preserved across the index wrap, count returns to 0.
- Simultaneous push/pop at count=16 (full):
  - Pop succeeds, push ignored, count=15.
  - Next cycle push is accepted, count=16.
- Transmitter-paced drain:
  - Model enq_ready=1 for 1 cycle every 10 cycles, with a 20-byte random burst from the producer.
  - Expect every byte delivered exactly once and in order, and no byte lost under backpressure.
- With UART_TX_FIFO_FLUSH_EN:
  - Count=7, pulse io_flush together with enq_valid -> next cycle count=0, io_deq_valid=0, enqueued byte discarded, io_max_level=7.
